// File: rtl/ram8_pkg.sv
// rtl/ram8_pkg.sv - shared Hack word/RAM8 geometry and the load demux helper
package ram8_pkg;

  // Hack word width and RAM8 geometry.
  localparam int WORD_W      = 16;
  localparam int RAM8_DEPTH  = 8;
  localparam int RAM8_ADDR_W = 3;

  // 1-to-8 load demultiplexer (dmux8way).
  // Exactly one output bit carries `load`; the other seven are 0.
  function automatic logic [RAM8_DEPTH-1:0] dmux8way(
    input logic                   load,
    input logic [RAM8_ADDR_W-1:0] sel
  );
    logic [RAM8_DEPTH-1:0] r_sel;
    r_sel      = '0;
    r_sel[sel] = load;
    return r_sel;
  endfunction

endpackage

// File: rtl/ram8_if.sv
// rtl/ram8_if.sv - RAM8 access bus: write data, load, address and read data
interface ram8_if
  import ram8_pkg::*;
#(
  parameter int WIDTH = WORD_W
) ();

  logic [WIDTH-1:0]       in;
  logic                   load;
  logic [RAM8_ADDR_W-1:0] address;
  logic [WIDTH-1:0]       out;

  // The requester drives the write side and reads back `out`.
  modport master (
    output in,
    output load,
    output address,
    input  out
  );

  // The memory accepts the write side and drives `out`.
  modport slave (
    input  in,
    input  load,
    input  address,
    output out
  );

endinterface

// File: rtl/ram8_register16.sv
// rtl/ram8_register16.sv - WIDTH-bit register with load and synchronous reset
module ram8_register16
  import ram8_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Each bit is a DFF with a load mux; reset wins over load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ram8.sv
// rtl/ram8.sv - eight-word WIDTH-bit RAM: dmux'd loads, mux'd combinational read
module ram8
  import ram8_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic   i_clk,
  input  logic   i_reset,
  ram8_if.slave  bus
);

  logic [RAM8_DEPTH-1:0] w_load;
  logic [WIDTH-1:0]      w_words [RAM8_DEPTH];
  logic [WIDTH-1:0]      w_out;

  // Split the write enable into one load per word.
  always_comb begin
    w_load = dmux8way(bus.load, bus.address);
  end

  // Eight word registers; only the addressed one sees load.
  for (genvar g = 0; g < RAM8_DEPTH; g++) begin : g_word
    ram8_register16 #(
      .WIDTH (WIDTH)
    ) u_word (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_load[g]),
      .i_d     (bus.in),
      .o_q     (w_words[g])
    );
  end

  // 8-way word mux: zero-latency read of the stored word, no write-through.
  always_comb begin
    w_out = w_words[bus.address];
  end

  assign bus.out = w_out;

endmodule

// File: tb/tb_ram8.sv
// tb/tb_ram8.sv - table-driven and hand-sequenced checks for ram8
module tb_ram8;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  ram8_if #(.WIDTH(16)) bus ();

  ram8 #(
    .WIDTH (16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ld;
    logic [2:0]  addr;
    logic [15:0] din;
    logic        chk_pre;
    logic [15:0] exp_pre;
    logic [15:0] exp_post;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ld, input logic [2:0] a,
                     input logic [15:0] d, input logic cp,
                     input logic [15:0] ep, input logic [15:0] eo,
                     input string nm);
    vec_t v;
    v.rst = r; v.ld = ld; v.addr = a; v.din = d;
    v.chk_pre = cp; v.exp_pre = ep; v.exp_post = eo; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%h expected=%h", nm, act, exp);
    end
  endtask

  initial begin
    logic [15:0] v16;
    n_checks = 0;
    n_fail   = 0;
    rst         = 1'b0;
    bus.in      = '0;
    bus.load    = 1'b0;
    bus.address = '0;

    // Reset, then sweep all addresses expecting zero.
    add(1, 0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, "reset");
    for (int i = 0; i < 8; i++)
      add(0, 0, 3'(i), 16'hFFFF, 1, 16'h0000, 16'h0000, "rd_after_reset");

    // Write 0x1111*(N+1) to each word, then read all back.
    for (int i = 0; i < 8; i++) begin
      v16 = 16'(16'h1111 * (i + 1));
      add(0, 1, 3'(i), v16, 1, 16'h0000, v16, "write_each");
    end
    for (int i = 0; i < 8; i++) begin
      v16 = 16'(16'h1111 * (i + 1));
      add(0, 0, 3'(i), 16'h0000, 1, v16, v16, "readback_each");
    end

    // Same-cycle read-before-write on word 3.
    add(0, 1, 3'd3, 16'h1234, 1, 16'h4444, 16'h1234, "w3_1234");
    add(0, 1, 3'd3, 16'hBEEF, 1, 16'h1234, 16'hBEEF, "rbw_w3");

    // Load isolation on word 5.
    add(0, 1, 3'd5, 16'h5555, 1, 16'h6666, 16'h5555, "w5_5555");
    for (int i = 0; i < 3; i++)
      add(0, 0, 3'd5, 16'hFFFF, 1, 16'h5555, 16'h5555, "w5_noload");
    add(0, 1, 3'd2, 16'h0001, 1, 16'h3333, 16'h0001, "w2_0001");
    add(0, 0, 3'd5, 16'h0000, 1, 16'h5555, 16'h5555, "w5_after_w2");

    // Reset priority over load on word 7.
    add(0, 1, 3'd7, 16'hAAAA, 1, 16'h8888, 16'hAAAA, "w7_aaaa");
    add(1, 1, 3'd7, 16'h7777, 1, 16'hAAAA, 16'h0000, "rst_vs_load");
    for (int i = 0; i < 8; i++)
      add(0, 0, 3'(i), 16'h0000, 1, 16'h0000, 16'h0000, "rd_after_rst_prio");

    // Back-to-back writes on word 0; word 1 must hold.
    add(0, 1, 3'd1, 16'h00C1, 1, 16'h0000, 16'h00C1, "w1_00c1");
    add(0, 1, 3'd0, 16'h0001, 1, 16'h0000, 16'h0001, "b2b_first");
    add(0, 1, 3'd0, 16'h0002, 1, 16'h0001, 16'h0002, "b2b_second");
    add(0, 0, 3'd1, 16'h0000, 1, 16'h00C1, 16'h00C1, "w1_held");
    add(0, 0, 3'd0, 16'h0000, 1, 16'h0002, 16'h0002, "w0_final");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      bus.load    = vecs[i].ld;
      bus.address = vecs[i].addr;
      bus.in      = vecs[i].din;
      #1;
      if (vecs[i].chk_pre)
        check($sformatf("%s[%0d] pre", vecs[i].name, i), bus.out, vecs[i].exp_pre);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] post", vecs[i].name, i), bus.out, vecs[i].exp_post);
    end

    // Between edges: out follows address only, never in/load or a reset glitch.
    @(negedge clk);
    rst = 1'b0; bus.load = 1'b0; bus.address = 3'd1; bus.in = 16'h0000;
    #1 check("hold_addr1", bus.out, 16'h00C1);
    bus.in = 16'hFFFF; bus.load = 1'b1;
    #1 check("in_load_no_effect", bus.out, 16'h00C1);
    bus.address = 3'd0;
    #1 check("addr_zero_latency", bus.out, 16'h0002);
    bus.load = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("async_rst_ignored", bus.out, 16'h0002);

    // Three consecutive writes on word 4: each visible for exactly one cycle.
    @(negedge clk);
    bus.address = 3'd4; bus.load = 1'b1; bus.in = 16'h0A0A;
    @(posedge clk);
    #1 check("b2b4_a", bus.out, 16'h0A0A);
    @(negedge clk);
    bus.in = 16'h0B0B;
    #1 check("b2b4_a_hold", bus.out, 16'h0A0A);
    @(posedge clk);
    #1 check("b2b4_b", bus.out, 16'h0B0B);
    @(negedge clk);
    bus.in = 16'h0C0C;
    @(posedge clk);
    #1 check("b2b4_c", bus.out, 16'h0C0C);
    @(negedge clk);
    bus.load = 1'b0; bus.in = 16'h1234;
    @(posedge clk);
    #1 check("b2b4_last_wins", bus.out, 16'h0C0C);
    bus.address = 3'd1;
    #1 check("b2b4_w1_intact", bus.out, 16'h00C1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
